// File: rtl/clyde_arb_pkg.sv
// Shared definitions for the Clyde-128 request arbiter: FSM encoding,
// default counter width and a small grant-decoding helper.
package clyde_arb_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/clyde_req_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: prio breaks ties, a lone request
// always wins.
module rr_arb2
    import clyde_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt,
    output logic       gid
);

    // Grant decode from the request pair and the priority pointer.
    always_comb begin
        gid = 1'b0;
        gnt = 2'b00;
        case (req)
            2'b01: begin
                gid = 1'b0;
                gnt = 2'b01;
            end
            2'b10: begin
                gid = 1'b1;
                gnt = 2'b10;
            end
            2'b11: begin
                gid = prio;
                gnt = id_to_onehot(prio);
            end
            default: begin
                gid = 1'b0;
                gnt = 2'b00;
            end
        endcase
    end

endmodule

// File: rtl/clyde_req_arbiter.sv
// Time-shares one masked Clyde-128 core between two requesters: arbitrates,
// launches a run, holds the operands, and returns the result over valid/ready.
module clyde_req_arbiter
    import clyde_arb_pkg::*;
#(
    parameter int Nbits = 128,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               pre_syn_rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [1:0]         req_inverse,
    input  logic [2*Nbits-1:0] req_data,
    input  logic [2*Nbits-1:0] req_tweak,
    output logic [1:0]         resp_valid,
    input  logic [1:0]         resp_ready,
    output logic [Nbits-1:0]   resp_data,
    input  logic               core_ready_start_run,
    output logic               core_pre_data_in_valid,
    output logic               core_inverse,
    output logic [Nbits-1:0]   core_data_in,
    output logic [Nbits-1:0]   core_tweak,
    input  logic [Nbits-1:0]   core_data_out,
    input  logic               core_pre_data_out_valid,
    output logic               busy,
    output logic               grant_id,
    output logic [CNT_W-1:0]   last_run_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic               r_prio;
    logic               r_grant_id;
    logic               r_launch;
    logic [1:0]         r_resp_valid;
    logic [Nbits-1:0]   r_resp_data;
    logic [Nbits-1:0]   r_core_data;
    logic [Nbits-1:0]   r_core_tweak;
    logic               r_core_inv;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_last;

    logic [1:0]         w_gnt;
    logic               w_gid;
    logic               w_accept;

    rr_arb2 u_rr_arb2 (
        .req  (req_valid),
        .prio (r_prio),
        .gnt  (w_gnt),
        .gid  (w_gid)
    );

    // The core's readiness only matters while waiting for a new request.
    assign w_accept = (r_state == ST_IDLE) && core_ready_start_run && (req_valid != 2'b00);

    // Acceptance is signalled in the same cycle the operands are sampled.
    always_comb begin
        if (w_accept) begin
            req_ready = w_gnt;
        end else begin
            req_ready = 2'b00;
        end
    end

    // Run sequencing, operand holding and result capture.
    always_ff @(posedge clk) begin
        if (pre_syn_rst) begin
            r_state      <= ST_IDLE;
            r_prio       <= 1'b0;
            r_grant_id   <= 1'b0;
            r_launch     <= 1'b0;
            r_resp_valid <= 2'b00;
            r_resp_data  <= '0;
            r_core_data  <= '0;
            r_core_tweak <= '0;
            r_core_inv   <= 1'b0;
            r_cnt        <= '0;
            r_last       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_core_data  <= w_gid ? req_data[2*Nbits-1:Nbits]  : req_data[Nbits-1:0];
                        r_core_tweak <= w_gid ? req_tweak[2*Nbits-1:Nbits] : req_tweak[Nbits-1:0];
                        r_core_inv   <= req_inverse[w_gid];
                        r_grant_id   <= w_gid;
                        r_launch     <= 1'b1;
                        r_state      <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_launch <= 1'b0;
                    r_cnt    <= '0;
                    r_state  <= ST_RUN;
                end
                ST_RUN: begin
                    // The cycle carrying the core's pre-valid is itself counted.
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                    if (core_pre_data_out_valid) begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_resp_data  <= core_data_out;
                    r_last       <= r_cnt;
                    r_resp_valid <= id_to_onehot(r_grant_id);
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready[r_grant_id]) begin
                        r_resp_valid <= 2'b00;
                        r_prio       <= ~r_grant_id;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign resp_valid             = r_resp_valid;
    assign resp_data              = r_resp_data;
    assign core_pre_data_in_valid = r_launch;
    assign core_inverse           = r_core_inv;
    assign core_data_in           = r_core_data;
    assign core_tweak             = r_core_tweak;
    assign busy                   = (r_state != ST_IDLE);
    assign grant_id               = r_grant_id;
    assign last_run_cycles        = r_last;

endmodule

// File: tb/tb_clyde_req_arbiter.sv
// Randomized self-checking bench for clyde_req_arbiter with a transaction-level
// reference model and a behavioural Clyde core stand-in.
module tb_clyde_req_arbiter;

    localparam int Nbits = 128;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    logic               clk = 1'b0;
    logic               pre_syn_rst;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [1:0]         req_inverse;
    logic [2*Nbits-1:0] req_data;
    logic [2*Nbits-1:0] req_tweak;
    logic [1:0]         resp_valid;
    logic [1:0]         resp_ready;
    logic [Nbits-1:0]   resp_data;
    logic               core_ready_start_run;
    logic               core_pre_data_in_valid;
    logic               core_inverse;
    logic [Nbits-1:0]   core_data_in;
    logic [Nbits-1:0]   core_tweak;
    logic [Nbits-1:0]   core_data_out;
    logic               core_pre_data_out_valid;
    logic               busy;
    logic               grant_id;
    logic [CNT_W-1:0]   last_run_cycles;

    int n_checks = 0;
    int n_errors = 0;

    logic             m_prio;
    logic             m_pv;
    logic             stray_pv;
    int               m_cd;
    int               core_lat;
    logic [Nbits-1:0] m_d;
    logic [Nbits-1:0] m_t;
    logic             m_inv;
    logic [Nbits-1:0] m_dout;

    clyde_req_arbiter #(.Nbits(Nbits), .CNT_W(CNT_W)) dut (
        .clk                     (clk),
        .pre_syn_rst             (pre_syn_rst),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_inverse             (req_inverse),
        .req_data                (req_data),
        .req_tweak               (req_tweak),
        .resp_valid              (resp_valid),
        .resp_ready              (resp_ready),
        .resp_data               (resp_data),
        .core_ready_start_run    (core_ready_start_run),
        .core_pre_data_in_valid  (core_pre_data_in_valid),
        .core_inverse            (core_inverse),
        .core_data_in            (core_data_in),
        .core_tweak              (core_tweak),
        .core_data_out           (core_data_out),
        .core_pre_data_out_valid (core_pre_data_out_valid),
        .busy                    (busy),
        .grant_id                (grant_id),
        .last_run_cycles         (last_run_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] ref_core(input logic [127:0] d, input logic [127:0] t, input logic inv);
        return inv ? ~(d ^ t) : (d + t);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Core stand-in: pre-valid core_lat cycles after launch, result one cycle later.
    always @(posedge clk) begin
        if (pre_syn_rst) begin
            m_pv   <= 1'b0;
            m_cd   <= 0;
            m_dout <= '0;
        end else begin
            m_pv <= 1'b0;
            if (core_pre_data_in_valid) begin
                m_d   <= core_data_in;
                m_t   <= core_tweak;
                m_inv <= core_inverse;
                if (core_lat <= 1) m_pv <= 1'b1;
                else m_cd <= core_lat - 1;
            end else if (m_cd > 0) begin
                m_cd <= m_cd - 1;
                if (m_cd == 1) m_pv <= 1'b1;
            end
            if (m_pv) m_dout <= ref_core(m_d, m_t, m_inv);
        end
    end

    assign core_data_out           = m_dout;
    assign core_pre_data_out_valid = m_pv | stray_pv;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at a negedge in IDLE.
    task automatic do_txn(input logic [1:0] valid, input int nr, input int lat, input int bp, input bit fixed);
        logic [127:0]     d0, d1, t0, t1, ed, et, eo, hold_data;
        logic [1:0]       inv, oh;
        logic             g;
        logic [CNT_W-1:0] elast;
        int               n;
        bit               stable, quiet, hold_ok;
        d0  = rnd128();
        d1  = rnd128();
        t0  = rnd128();
        t1  = rnd128();
        inv = 2'($urandom_range(0, 3));
        if (fixed) begin
            d0     = 128'h0123456789ABCDEF0123456789ABCDEF;
            t0     = 128'd0;
            inv[0] = 1'b0;
        end
        g     = (valid == 2'b11) ? m_prio : valid[1];
        oh    = g ? 2'b10 : 2'b01;
        ed    = g ? d1 : d0;
        et    = g ? t1 : t0;
        eo    = ref_core(ed, et, inv[g]);
        elast = (lat > 255) ? CNT_MAX : lat[CNT_W-1:0];
        core_lat    = lat;
        req_valid   = valid;
        req_data    = {d1, d0};
        req_tweak   = {t1, t0};
        req_inverse = inv;
        resp_ready  = 2'b00;
        core_ready_start_run = 1'b0;
        for (int i = 0; i < nr; i++) begin
            #1 check_eq("req_ready_core_not_ready", 128'(req_ready), 128'd0);
            @(negedge clk);
        end
        core_ready_start_run = 1'b1;
        #1 check_eq("accept_req_ready", 128'(req_ready), 128'(oh));
        @(negedge clk);
        check_eq("launch_pulse", 128'(core_pre_data_in_valid), 128'd1);
        check_eq("core_data_in", core_data_in, ed);
        check_eq("core_tweak", core_tweak, et);
        check_eq("core_inverse", 128'(core_inverse), 128'(inv[g]));
        check_eq("grant_id", 128'(grant_id), 128'(g));
        check_eq("busy_in_run", 128'(busy), 128'd1);
        core_ready_start_run = 1'($urandom_range(0, 1));
        n = 0;
        stable = 1'b1;
        quiet  = 1'b1;
        while (resp_valid == 2'b00 && n < lat + 20) begin
            @(negedge clk);
            n++;
            if (core_data_in !== ed || core_tweak !== et || core_inverse !== inv[g]) stable = 1'b0;
            if (req_ready !== 2'b00 || core_pre_data_in_valid !== 1'b0) quiet = 1'b0;
            core_ready_start_run = 1'($urandom_range(0, 1));
        end
        check_eq("resp_latency", 128'(n), 128'(lat + 2));
        check_eq("core_inputs_stable", 128'(stable), 128'd1);
        check_eq("no_accept_no_relaunch", 128'(quiet), 128'd1);
        check_eq("resp_valid", 128'(resp_valid), 128'(oh));
        check_eq("resp_data", resp_data, eo);
        check_eq("last_run_cycles", 128'(last_run_cycles), 128'(elast));
        hold_data = resp_data;
        hold_ok   = 1'b1;
        for (int i = 0; i < bp; i++) begin
            resp_ready = ~oh & 2'($urandom_range(0, 3));
            stray_pv   = (i == 0);
            @(negedge clk);
            if (resp_valid !== oh || resp_data !== hold_data || req_ready !== 2'b00 || busy !== 1'b1)
                hold_ok = 1'b0;
        end
        check_eq("backpressure_hold", 128'(hold_ok), 128'd1);
        stray_pv   = 1'b0;
        resp_ready = oh | (~oh & 2'($urandom_range(0, 3)));
        #1 check_eq("handshake_req_ready", 128'(req_ready), 128'd0);
        @(negedge clk);
        check_eq("resp_valid_cleared", 128'(resp_valid), 128'd0);
        check_eq("busy_after_handshake", 128'(busy), 128'd0);
        resp_ready           = 2'b00;
        core_ready_start_run = 1'b0;
        m_prio               = ~g;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_req_ready"}, 128'(req_ready), 128'd0);
        check_eq({tag, "_resp_valid"}, 128'(resp_valid), 128'd0);
        check_eq({tag, "_launch"}, 128'(core_pre_data_in_valid), 128'd0);
        check_eq({tag, "_busy"}, 128'(busy), 128'd0);
        check_eq({tag, "_grant_id"}, 128'(grant_id), 128'd0);
        check_eq({tag, "_resp_data"}, resp_data, 128'd0);
        check_eq({tag, "_core_data_in"}, core_data_in, 128'd0);
        check_eq({tag, "_core_tweak"}, core_tweak, 128'd0);
        check_eq({tag, "_core_inverse"}, 128'(core_inverse), 128'd0);
        check_eq({tag, "_last_run_cycles"}, 128'(last_run_cycles), 128'd0);
    endtask

    initial begin
        bit quiet;
        pre_syn_rst          = 1'b1;
        req_valid            = 2'b00;
        req_inverse          = 2'b00;
        req_data             = '0;
        req_tweak            = '0;
        resp_ready           = 2'b00;
        core_ready_start_run = 1'b0;
        stray_pv             = 1'b0;
        core_lat             = 10;
        m_prio               = 1'b0;
        repeat (3) @(negedge clk);
        pre_syn_rst = 1'b0;
        check_reset_values("reset");

        // Stray pre-valid while idle must not start anything.
        stray_pv = 1'b1;
        @(negedge clk);
        stray_pv = 1'b0;
        check_eq("stray_idle_busy", 128'(busy), 128'd0);
        check_eq("stray_idle_resp", 128'(resp_valid), 128'd0);

        do_txn(2'b01, 0, 40, 0, 1'b1);
        for (int k = 0; k < 4; k++) do_txn(2'b11, 0, int'($urandom_range(3, 30)), 0, 1'b0);
        do_txn(2'b10, 5, 12, 0, 1'b0);
        do_txn(2'b10, 0, 15, 20, 1'b0);
        for (int k = 0; k < 8; k++)
            do_txn(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(1, 60)), int'($urandom_range(0, 4)), 1'b0);
        do_txn(2'b01, 0, 300, 0, 1'b0);

        // Reset in the middle of a run drops the pending response.
        req_valid            = 2'b01;
        req_data             = {rnd128(), rnd128()};
        req_tweak            = {rnd128(), rnd128()};
        core_lat             = 100;
        core_ready_start_run = 1'b1;
        #1 check_eq("rst_run_accept", 128'(req_ready), 128'(m_prio ? 2'b01 : 2'b01));
        repeat (12) @(negedge clk);
        check_eq("rst_run_busy", 128'(busy), 128'd1);
        pre_syn_rst          = 1'b1;
        req_valid            = 2'b00;
        core_ready_start_run = 1'b0;
        @(negedge clk);
        pre_syn_rst = 1'b0;
        check_reset_values("midrun_reset");
        quiet = 1'b1;
        repeat (120) begin
            @(negedge clk);
            if (resp_valid !== 2'b00 || busy !== 1'b0) quiet = 1'b0;
        end
        check_eq("midrun_reset_no_resp", 128'(quiet), 128'd1);
        m_prio = 1'b0;
        do_txn(2'b10, 0, 20, 0, 1'b0);
        do_txn(2'b11, 0, 9, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
